boom_key_judge: RTL and testbench
=================================

# boom_key_judge

Player-input side of the seven-boom counter game. It synchronises and debounces the player's active-low push button and captures at most one press per count period. At each count advance it scores the closing period against the boom flag of the number being displayed. Hit and miss totals are produced as two-digit BCD for the existing hex decoders, plus a verdict LED.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive stable synchronised samples needed to accept a button level change (10 ms at 50 MHz); minimum 2.

Ports:
- CLOCK_50  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state.
- key_n  input  1  raw push button, 0 = pressed; asynchronous to CLOCK_50.
- tick  input  1  one-cycle pulse from the frequency divider; the count advances after this cycle.
- boom  input  1  boom flag of the currently displayed count; valid and stable throughout a period, including the tick cycle.
- press_pulse  output  1  one-cycle pulse per accepted press.
- hit_tens, hit_ones  output  4 each  BCD hit total, 00–99.
- miss_tens, miss_ones  output  4 each  BCD miss total, 00–99.
- verdict_led  output  1  1 = last evaluated period was judged correct.

## Operation

- **Synchroniser:** 2-flop chain on key_n, producing key_s; reset value 1.
- **Debounce FSM:** states UP (reset), FALLING, DOWN, RISING; a counter of width $clog2(DEBOUNCE_CYCLES) is cleared on every state entry.
  - UP: on key_s=0, go to FALLING.
  - FALLING: on key_s=1, return to UP. If key_s=0 and the counter equals DEBOUNCE_CYCLES-2, go to DOWN and assert press_pulse for that cycle.
  - DOWN: on key_s=1, go to RISING.
  - RISING: on key_s=0, return to DOWN. If key_s=1 and the counter equals DEBOUNCE_CYCLES-2, go to UP.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- **Period capture:** flag `pressed` is set by press_pulse and cleared on the cycle after tick.
  - A press_pulse coincident with tick belongs to the closing period.
  - Only the first press in a period matters; extra presses are ignored.
- **Evaluation**, on the tick cycle, using boom and (pressed OR press_pulse):
  - boom=1, pressed: hit += 1, verdict_led ← 1.
  - boom=1, not pressed: miss += 1, verdict_led ← 0.
  - boom=0, pressed: behaviour set by FALSE_PRESS_EN (see Configuration).
  - boom=0, not pressed: no count change, verdict_led ← 1.
- **BCD arithmetic:**
  - Each increment: ones 9 → 0 with tens +1.
  - Saturates at 99; further increments hold 99.
  - Digits never leave 0–9.
- **Reset:** asynchronous assertion at any point, including mid-debounce or on the tick cycle. All outputs and state go to 0, except key_s = 1 and FSM = UP. The first period starts at reset release.

## Timing

- press_pulse latency: key_n held low from before rising edge k pulses in the cycle following edge k+1+DEBOUNCE_CYCLES.
  - 2 cycles synchroniser, then DEBOUNCE_CYCLES-1 cycles of stability.
- Score and verdict_led update on the rising edge ending the tick cycle; visible in the cycle after tick.
- All outputs are registered; no combinational path from inputs to outputs.
- Back-to-back tick pulses, one cycle apart, are each evaluated.
  - A period can be a single cycle; `pressed` clears correctly.

## Configuration

- FALSE_PRESS_EN defined: a press in a boom=0 period gives miss += 1 and verdict_led ← 0.
- FALSE_PRESS_EN undefined: such presses are ignored, with no count change and verdict_led ← 1. All other logic is identical.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.
- **Reset and debounce latency:** rst=0 then released, key_n=1.
  - All digits, verdict_led and press_pulse read 0.
  - key_n low from edge 10 → press_pulse high exactly in the cycle after edge 15.
- **Glitch rejection:** key_n low for 3 cycles, then high → no press_pulse, FSM returns to UP. A 3-cycle high blip during DOWN → no second pulse.
- **Hit and miss:**
  - boom=1 period with one press, then tick → hit 01, verdict_led 1.
  - Next boom=1 period without a press, then tick → miss 01, verdict_led 0.
- **Coincident press and tick:** press_pulse on the tick cycle with boom=1 → hit increments once. The next period's `pressed` is 0.
- **False press:** boom=0 period with a press, then tick.
  - With FALSE_PRESS_EN: miss 01, verdict_led 0.
  - Without it: counts unchanged, verdict_led 1.
- **BCD wrap, saturation and reset:**
  - 9 hits → 09; 10th → 10; 99 → 99; 100th → stays 99.
  - rst asserted mid-FALLING → everything clears; no press_pulse after release.

Source files
------------

// File: rtl/boom_key_judge.sv
// Player button debounce, per-period press capture and BCD hit/miss scoring.
// Optional FALSE_PRESS_EN: a press in a boom=0 period scores as a miss.
module boom_key_judge #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       key_n,
    input  logic       tick,
    input  logic       boom,
    output logic       press_pulse,
    output logic [3:0] hit_tens,
    output logic [3:0] hit_ones,
    output logic [3:0] miss_tens,
    output logic [3:0] miss_ones,
    output logic       verdict_led
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_END = CW'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {
        UP      = 2'd0,
        FALLING = 2'd1,
        DOWN    = 2'd2,
        RISING  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          pulse_nx;
    logic          key_m;
    logic          key_s;
    logic          pressed;
    logic          took;
    logic          hit_inc;
    logic          miss_inc;
    logic          false_miss;
    logic [7:0]    hit_bcd;
    logic [7:0]    miss_bcd;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            key_m <= 1'b1;
            key_s <= 1'b1;
        end else begin
            key_m <= key_n;
            key_s <= key_m;
        end
    end

    // Counter only runs while waiting out a transition; it restarts on entry.
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        pulse_nx = 1'b0;
        unique case (state)
            UP: begin
                if (!key_s)
                    state_nx = FALLING;
            end
            FALLING: begin
                if (key_s) begin
                    state_nx = UP;
                end else if (cnt == CNT_END) begin
                    state_nx = DOWN;
                    pulse_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            DOWN: begin
                if (key_s)
                    state_nx = RISING;
            end
            RISING: begin
                if (!key_s)
                    state_nx = DOWN;
                else if (cnt == CNT_END)
                    state_nx = UP;
                else
                    cnt_nx = cnt + CW'(1);
            end
            default: state_nx = UP;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state       <= UP;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            press_pulse <= pulse_nx;
        end
    end

    // A pulse landing on the tick cycle still belongs to the closing period.
    assign took = pressed | press_pulse;

`ifdef FALSE_PRESS_EN
    assign false_miss = ~boom & took;
`else
    assign false_miss = 1'b0;
`endif

    assign hit_inc  = tick & boom & took;
    assign miss_inc = tick & ((boom & ~took) | false_miss);

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            pressed     <= 1'b0;
            hit_bcd     <= 8'h00;
            miss_bcd    <= 8'h00;
            verdict_led <= 1'b0;
        end else begin
            if (tick)
                pressed <= 1'b0;
            else if (press_pulse)
                pressed <= 1'b1;
            if (hit_inc)
                hit_bcd <= bcd_inc(hit_bcd);
            if (miss_inc)
                miss_bcd <= bcd_inc(miss_bcd);
            if (tick)
                verdict_led <= ~miss_inc;
        end
    end

    assign hit_tens  = hit_bcd[7:4];
    assign hit_ones  = hit_bcd[3:0];
    assign miss_tens = miss_bcd[7:4];
    assign miss_ones = miss_bcd[3:0];

endmodule

// File: tb/tb_boom_key_judge.sv
// Directed bench for boom_key_judge with DEBOUNCE_CYCLES=4.
// Expectations follow FALSE_PRESS_EN when it is defined for the build.
module tb_boom_key_judge;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_n;
    logic       tick;
    logic       boom;
    logic       press_pulse;
    logic [3:0] hit_tens;
    logic [3:0] hit_ones;
    logic [3:0] miss_tens;
    logic [3:0] miss_ones;
    logic       verdict_led;

    int n_checks = 0;
    int errors   = 0;
    int exp_hit  = 0;
    int exp_miss = 0;

    boom_key_judge #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50    (clk),
        .rst         (rst),
        .key_n       (key_n),
        .tick        (tick),
        .boom        (boom),
        .press_pulse (press_pulse),
        .hit_tens    (hit_tens),
        .hit_ones    (hit_ones),
        .miss_tens   (miss_tens),
        .miss_ones   (miss_ones),
        .verdict_led (verdict_led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic watch(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            cyc(1);
            if (press_pulse)
                pulses++;
        end
    endtask

    task automatic press();
        int found;
        found = 0;
        key_n = 1'b0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            cyc(1);
            if (press_pulse)
                found = 1;
        end
        chk("press_seen", found, 1);
        key_n = 1'b1;
        cyc(10);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic chk_score(input string tag, input int verdict);
        chk({tag, "_hit_tens"}, int'(hit_tens), exp_hit / 10);
        chk({tag, "_hit_ones"}, int'(hit_ones), exp_hit % 10);
        chk({tag, "_miss_tens"}, int'(miss_tens), exp_miss / 10);
        chk({tag, "_miss_ones"}, int'(miss_ones), exp_miss % 10);
        chk({tag, "_verdict"}, int'(verdict_led), verdict);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        exp_hit  = 0;
        exp_miss = 0;
    endtask

    initial begin
        int p;
        rst   = 1'b0;
        key_n = 1'b1;
        tick  = 1'b0;
        boom  = 1'b0;
        cyc(3);
        chk_score("reset", 0);
        chk("reset_pulse", int'(press_pulse), 0);
        rst = 1'b1;

        // key_n low just after edge e: pulse visible after edge e+6
        cyc(2);
        key_n = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            cyc(1);
            chk($sformatf("latency_edge%0d", j), int'(press_pulse), (j == 6) ? 1 : 0);
        end
        key_n = 1'b1;
        watch(12, p);
        chk("release_nopulse", p, 0);

        key_n = 1'b0;
        cyc(3);
        key_n = 1'b1;
        watch(10, p);
        chk("glitch_nopulse", p, 0);
        chk("glitch_up", int'(dut.state), 0);

        key_n = 1'b0;
        watch(10, p);
        chk("hold_one_pulse", p, 1);
        key_n = 1'b1;
        watch(3, p);
        key_n = 1'b0;
        begin
            int q;
            watch(10, q);
            chk("down_blip_nopulse", p + q, 0);
        end
        key_n = 1'b1;
        watch(12, p);
        chk("down_release_nopulse", p, 0);

        do_reset();
        boom = 1'b1;
        press();
        do_tick();
        exp_hit = 1;
        chk_score("hit", 1);

        do_tick();
        exp_miss = 1;
        chk_score("miss", 0);

        key_n = 1'b0;
        cyc(6);
        chk("coincident_pulse", int'(press_pulse), 1);
        do_tick();
        exp_hit = 2;
        chk_score("coincident", 1);
        key_n = 1'b1;
        cyc(10);
        do_tick();
        exp_miss = 2;
        chk_score("after_coincident", 0);

        boom = 1'b0;
        press();
        do_tick();
`ifdef FALSE_PRESS_EN
        exp_miss = 3;
        chk_score("false_press", 0);
`else
        chk_score("false_press", 1);
`endif
        cyc(3);
        do_tick();
        chk_score("quiet_boom0", 1);

        boom = 1'b1;
        press();
        tick = 1'b1;
        cyc(1);
        exp_hit++;
        chk_score("b2b_first", 1);
        cyc(1);
        tick = 1'b0;
        exp_miss++;
        chk_score("b2b_second", 0);

        do_reset();
        boom = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            press();
            do_tick();
            exp_hit = (i > 99) ? 99 : i;
            if (i == 9 || i == 10 || i == 99 || i == 100)
                chk_score($sformatf("bcd_%0d", i), 1);
        end

        key_n = 1'b0;
        cyc(3);
        #2;
        rst = 1'b0;
        #1;
        exp_hit  = 0;
        exp_miss = 0;
        chk_score("async_rst", 0);
        chk("async_rst_pulse", int'(press_pulse), 0);
        chk("async_rst_up", int'(dut.state), 0);
        key_n = 1'b1;
        cyc(2);
        rst = 1'b1;
        watch(12, p);
        chk("post_rst_nopulse", p, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
